// File: rtl/popcount_pipe.sv
// ---------------------------------------------------------------------------
// popcount_pipe
//
// Parametrised, pipelined population counter behind a valid/ready handshake
// with full backpressure. Each accepted transaction counts either the one
// bits or the zero bits of i_data. The result comes back after STAGES cycles
// together with the transaction's sideband tag.
//
// The adder tree has L = $clog2(WIDTH) levels of pairwise adds. These levels
// are split as evenly as possible over the STAGES register stages. Each stage
// has its own valid flag, so bubbles collapse and there is no global stall.
//
// Parameters:
//   WIDTH     - input vector width (>= 1)
//   STAGES    - register stages = latency (1 .. max(1, $clog2(WIDTH)))
//   TAG_WIDTH - sideband tag width (>= 1)
//
// Ports:
//   i_clk, i_rst_n - clock, synchronous active-low reset
//   i_valid/o_ready - upstream handshake (o_ready has no path from i_valid)
//   i_data         - vector to count
//   i_mask         - only with POPCOUNT_PIPE_MASK_EN: positions to count
//   i_zeros        - 1 = count zeros, 0 = count ones
//   i_tag          - sideband, returned unchanged with the result
//   o_valid/i_ready - downstream handshake
//   o_count        - population count, $clog2(WIDTH+1) bits
//   o_tag          - tag of the result
//
// Optional feature macro: POPCOUNT_PIPE_MASK_EN. It adds the i_mask port.
// ---------------------------------------------------------------------------
module popcount_pipe #(
    parameter int WIDTH     = 32,
    parameter int STAGES    = 2,
    parameter int TAG_WIDTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [WIDTH-1:0]             i_data,
`ifdef POPCOUNT_PIPE_MASK_EN
    input  logic [WIDTH-1:0]             i_mask,
`endif
    input  logic                         i_zeros,
    input  logic [TAG_WIDTH-1:0]         i_tag,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [$clog2(WIDTH+1)-1:0]   o_count,
    output logic [TAG_WIDTH-1:0]         o_tag
);

    localparam int L          = (WIDTH > 1) ? $clog2(WIDTH) : 0;
    localparam int MAX_STAGES = (L > 1) ? L : 1;
    localparam int CW         = $clog2(WIDTH + 1);

    // Every lane is kept at the final count width. A partial sum can never
    // exceed WIDTH, so no level overflows. The unused upper bits of the early
    // levels are constant zero.
    typedef logic [WIDTH-1:0][CW-1:0] lanes_t;

    // Elaboration-time parameter checks
    if (WIDTH < 1) begin : g_err_width
        $error("popcount_pipe: WIDTH must be >= 1");
    end
    if (STAGES < 1) begin : g_err_stages_min
        $error("popcount_pipe: STAGES must be >= 1");
    end
    if (STAGES > MAX_STAGES) begin : g_err_stages_max
        $error("popcount_pipe: STAGES must be <= max(1, $clog2(WIDTH))");
    end

    // Applies the adder-tree levels lo .. hi-1 to a lane vector. Lane i feeds
    // lane i/2 of the next level. Lanes past the live operand count are zero,
    // so an odd trailing operand passes through unchanged.
    function automatic lanes_t reduce_levels(input lanes_t a, input int lo, input int hi);
        lanes_t cur;
        lanes_t nxt;
        cur = a;
        for (int j = 0; j < L; j++) begin
            if (j >= lo && j < hi) begin
                // NOTE: nxt is cleared before it is accumulated. Every bit then
                // has a defined value on each path through the loop, so no
                // storage is inferred.
                nxt = '0;
                for (int i = 0; i < WIDTH; i++) begin
                    nxt[i >> 1] = nxt[i >> 1] + cur[i];
                end
                cur = nxt;
            end
        end
        return cur;
    endfunction

    // Counted vector, evaluated at the accept cycle
    logic [WIDTH-1:0] counted;
    lanes_t           in_lanes;

`ifdef POPCOUNT_PIPE_MASK_EN
    assign counted = (i_zeros ? ~i_data : i_data) & i_mask;
`else
    assign counted = i_zeros ? ~i_data : i_data;
`endif

    always_comb begin
        in_lanes = '0;
        for (int i = 0; i < WIDTH; i++) begin
            in_lanes[i] = CW'(counted[i]);
        end
    end

    // Pipeline state
    lanes_t               stage_d  [STAGES];
    lanes_t               stage_q  [STAGES];
    logic [TAG_WIDTH-1:0] tag_in   [STAGES];
    logic [TAG_WIDTH-1:0] tag_q    [STAGES];
    logic [STAGES-1:0]    valid_in;
    logic [STAGES-1:0]    valid_q;
    logic [STAGES-1:0]    adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = (k * L) / STAGES;
        localparam int HI = ((k + 1) * L) / STAGES;

        if (k == 0) begin : g_first
            assign stage_d[k]  = reduce_levels(in_lanes, LO, HI);
            assign tag_in[k]   = i_tag;
            assign valid_in[k] = i_valid;
        end else begin : g_next
            assign stage_d[k]  = reduce_levels(stage_q[k-1], LO, HI);
            assign tag_in[k]   = tag_q[k-1];
            assign valid_in[k] = valid_q[k-1];
        end

        // A stage advances when it is empty or its successor advances. For
        // the last stage, the successor is the downstream consumer.
        if (k == STAGES - 1) begin : g_adv_last
            assign adv[k] = !valid_q[k] || i_ready;
        end else begin : g_adv_mid
            assign adv[k] = !valid_q[k] || adv[k+1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            valid_q <= '0;
            // NOTE: the datapath registers are cleared as well. The outputs then
            // read zero after reset and do not show stale data from the last
            // transaction in flight.
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
                tag_q[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (adv[k]) begin
                    // NOTE: every stage updates in the same edge from the old
                    // values of its predecessor. Non-blocking assignments keep
                    // the stages from collapsing into a single cycle.
                    valid_q[k] <= valid_in[k];
                    // Data only moves with a real transaction. Bubbles then
                    // leave the outputs unchanged.
                    if (valid_in[k]) begin
                        stage_q[k] <= stage_d[k];
                        tag_q[k]   <= tag_in[k];
                    end
                end
            end
        end
    end

    assign o_ready = adv[0];
    assign o_valid = valid_q[STAGES-1];
    assign o_count = stage_q[STAGES-1][0];
    assign o_tag   = tag_q[STAGES-1];

endmodule

// File: tb/tb_popcount_pipe.sv
// ---------------------------------------------------------------------------
// tb_popcount_pipe
//
// Directed testbench for popcount_pipe. It uses these instances:
//   dut    - WIDTH=32, STAGES=2 (main handshake and datapath scenarios)
//   dut_w1 - WIDTH=1,  STAGES=1
//   dut_w5 - WIDTH=5,  STAGES=2
//   dut_m8 - WIDTH=8,  STAGES=2, only when POPCOUNT_PIPE_MASK_EN is defined
//
// Inputs change 1 time unit after the rising edge, and outputs are checked
// at that same point.
// ---------------------------------------------------------------------------
module tb_popcount_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- main instance: WIDTH=32, STAGES=2 ----------------
    logic        in_valid, in_ready, in_zeros, out_valid, out_ready;
    logic [31:0] in_data;
    logic [3:0]  in_tag, out_tag;
    logic [5:0]  out_count;
`ifdef POPCOUNT_PIPE_MASK_EN
    logic [31:0] in_mask;
`endif

    popcount_pipe #(.WIDTH(32), .STAGES(2), .TAG_WIDTH(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  (in_data),
`ifdef POPCOUNT_PIPE_MASK_EN
        .i_mask  (in_mask),
`endif
        .i_zeros (in_zeros),
        .i_tag   (in_tag),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_count (out_count),
        .o_tag   (out_tag)
    );

    // ---------------- WIDTH=1, STAGES=1 ----------------
    logic       w1_valid, w1_in_ready, w1_zeros, w1_out_valid;
    logic [0:0] w1_data, w1_count;
    logic [3:0] w1_tag, w1_out_tag;
`ifdef POPCOUNT_PIPE_MASK_EN
    logic [0:0] w1_mask;
`endif

    popcount_pipe #(.WIDTH(1), .STAGES(1), .TAG_WIDTH(4)) dut_w1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (w1_valid),
        .o_ready (w1_in_ready),
        .i_data  (w1_data),
`ifdef POPCOUNT_PIPE_MASK_EN
        .i_mask  (w1_mask),
`endif
        .i_zeros (w1_zeros),
        .i_tag   (w1_tag),
        .o_valid (w1_out_valid),
        .i_ready (1'b1),
        .o_count (w1_count),
        .o_tag   (w1_out_tag)
    );

    // ---------------- WIDTH=5, STAGES=2 ----------------
    logic       w5_valid, w5_in_ready, w5_zeros, w5_out_valid;
    logic [4:0] w5_data;
    logic [2:0] w5_count;
    logic [3:0] w5_tag, w5_out_tag;
`ifdef POPCOUNT_PIPE_MASK_EN
    logic [4:0] w5_mask;
`endif

    popcount_pipe #(.WIDTH(5), .STAGES(2), .TAG_WIDTH(4)) dut_w5 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (w5_valid),
        .o_ready (w5_in_ready),
        .i_data  (w5_data),
`ifdef POPCOUNT_PIPE_MASK_EN
        .i_mask  (w5_mask),
`endif
        .i_zeros (w5_zeros),
        .i_tag   (w5_tag),
        .o_valid (w5_out_valid),
        .i_ready (1'b1),
        .o_count (w5_count),
        .o_tag   (w5_out_tag)
    );

`ifdef POPCOUNT_PIPE_MASK_EN
    // ---------------- WIDTH=8, STAGES=2, masked ----------------
    logic       m8_valid, m8_in_ready, m8_zeros, m8_out_valid;
    logic [7:0] m8_data, m8_mask;
    logic [3:0] m8_count;
    logic [3:0] m8_tag, m8_out_tag;

    popcount_pipe #(.WIDTH(8), .STAGES(2), .TAG_WIDTH(4)) dut_m8 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (m8_valid),
        .o_ready (m8_in_ready),
        .i_data  (m8_data),
        .i_mask  (m8_mask),
        .i_zeros (m8_zeros),
        .i_tag   (m8_tag),
        .o_valid (m8_out_valid),
        .i_ready (1'b1),
        .o_count (m8_count),
        .o_tag   (m8_out_tag)
    );
`endif

    // Stream vectors with hand-computed ones and zeros counts
    logic [31:0] stream_data [4];
    logic [5:0]  stream_ones [4];
    logic [5:0]  stream_zero [4];

    initial begin
        stream_data = '{32'h0000_0000, 32'h0000_0001, 32'h8000_0001, 32'hF0F0_F0F0};
        stream_ones = '{6'd0, 6'd1, 6'd2, 6'd16};
        stream_zero = '{6'd32, 6'd31, 6'd30, 6'd16};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_zeros  = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;
        w1_valid  = 1'b0; w1_data = '0; w1_zeros = 1'b0; w1_tag = '0;
        w5_valid  = 1'b0; w5_data = '0; w5_zeros = 1'b0; w5_tag = '0;
`ifdef POPCOUNT_PIPE_MASK_EN
        in_mask   = '1;
        w1_mask   = '1;
        w5_mask   = '1;
        m8_valid  = 1'b0; m8_data = '0; m8_mask = '1; m8_zeros = 1'b0; m8_tag = '0;
`endif

        // ---- reset ----
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("reset_o_valid", out_valid, 0);
        check("reset_o_count", out_count, 0);
        check("reset_o_tag",   out_tag,   0);
        check("reset_o_ready", in_ready,  1);

        // ---- single transaction, latency 2 ----
        in_valid = 1'b1; in_data = 32'hFFFF_FFFF; in_zeros = 1'b0; in_tag = 4'h3;
        tick();
        in_valid = 1'b0;
        check("lat_not_yet_valid", out_valid, 0);
        tick();
        check("lat_valid", out_valid, 1);
        check("lat_count", out_count, 32);
        check("lat_tag",   out_tag,   3);

        // ---- full-rate stream: ones, then zeros ----
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < 6; c++) begin
                if (c < 4) begin
                    in_valid = 1'b1;
                    in_data  = stream_data[c];
                    in_zeros = (m == 1);
                    in_tag   = 4'(c);
                end else begin
                    in_valid = 1'b0;
                end
                tick();
                if (c >= 1 && c <= 4) begin
                    check("stream_valid", out_valid, 1);
                    check("stream_count", out_count,
                          (m == 1) ? stream_zero[c-1] : stream_ones[c-1]);
                    check("stream_tag",   out_tag,   c - 1);
                end else begin
                    check("stream_idle", out_valid, 0);
                end
            end
        end

        // ---- backpressure: fill the pipe, stall 5 cycles ----
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h0000_00FF; in_zeros = 1'b0; in_tag = 4'h8;
        tick();
        check("bp_ready_one_full", in_ready, 1);
        in_data = 32'h0000_FFFF; in_tag = 4'h9;
        tick();
        in_data = 32'h0F00_0000; in_tag = 4'hA;   // held until the pipe drains
        for (int c = 0; c < 5; c++) begin
            check("bp_o_ready_low", in_ready,  0);
            check("bp_valid_held",  out_valid, 1);
            check("bp_count_held",  out_count, 8);
            check("bp_tag_held",    out_tag,   4'h8);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_ready_comb", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("bp_drain1_valid", out_valid, 1);
        check("bp_drain1_count", out_count, 16);
        check("bp_drain1_tag",   out_tag,   4'h9);
        tick();
        check("bp_drain2_valid", out_valid, 1);
        check("bp_drain2_count", out_count, 4);
        check("bp_drain2_tag",   out_tag,   4'hA);
        tick();
        check("bp_drain_empty", out_valid, 0);

        // ---- bubble collapse ----
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h0000_0001; in_tag = 4'h1;
        tick();
        in_valid = 1'b0;
        tick();
        check("bub_first_waiting", out_valid, 1);
        check("bub_ready_open",    in_ready,  1);
        in_valid = 1'b1; in_data = 32'h0000_0003; in_tag = 4'h2;
        tick();
        in_valid = 1'b0;
        check("bub_ready_full", in_ready,  0);
        check("bub_hold_count", out_count, 1);
        check("bub_hold_tag",   out_tag,   4'h1);
        out_ready = 1'b1;
        tick();
        check("bub_second_valid", out_valid, 1);
        check("bub_second_count", out_count, 2);
        check("bub_second_tag",   out_tag,   4'h2);
        tick();
        check("bub_empty", out_valid, 0);

        // ---- reset mid-flight ----
        in_valid = 1'b1; in_data = 32'hFFFF_0000; in_tag = 4'h5;
        tick();
        in_tag = 4'h6;
        tick();
        in_valid = 1'b0;
        check("rst_pre_valid", out_valid, 1);
        check("rst_pre_count", out_count, 16);
        check("rst_pre_tag",   out_tag,   4'h5);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_count", out_count, 0);
        check("rst_mid_tag",   out_tag,   0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_no_stale", out_valid, 0);
        end
        check("rst_ready", in_ready, 1);

        // ---- WIDTH=1, STAGES=1 ----
        w1_valid = 1'b1; w1_data = 1'b1; w1_zeros = 1'b0; w1_tag = 4'h7;
        tick();
        check("w1_valid", w1_out_valid, 1);
        check("w1_count", w1_count,     1);
        check("w1_tag",   w1_out_tag,   4'h7);
        w1_data = 1'b0; w1_zeros = 1'b1; w1_tag = 4'h2;
        tick();
        w1_valid = 1'b0;
        check("w1_zero_count", w1_count,   1);
        check("w1_zero_tag",   w1_out_tag, 4'h2);
        w1_data = 1'b1;
        tick();
        check("w1_idle", w1_out_valid, 0);

        // ---- WIDTH=5, STAGES=2 ----
        w5_valid = 1'b1; w5_data = 5'b10111; w5_zeros = 1'b0; w5_tag = 4'h1;
        tick();
        w5_zeros = 1'b1; w5_tag = 4'h2;
        tick();
        w5_valid = 1'b0;
        check("w5_valid",      w5_out_valid, 1);
        check("w5_count",      w5_count,     4);
        check("w5_tag",        w5_out_tag,   4'h1);
        tick();
        check("w5_zero_count", w5_count,     1);
        check("w5_zero_tag",   w5_out_tag,   4'h2);

`ifdef POPCOUNT_PIPE_MASK_EN
        // ---- mask: WIDTH=8 ----
        m8_valid = 1'b1; m8_data = 8'hFF; m8_mask = 8'h0F; m8_zeros = 1'b0; m8_tag = 4'h4;
        tick();
        m8_zeros = 1'b1; m8_tag = 4'h5;
        tick();
        m8_data = 8'h0F; m8_mask = 8'h3C; m8_zeros = 1'b0; m8_tag = 4'h6;
        check("m8_valid",      m8_out_valid, 1);
        check("m8_count",      m8_count,     4);
        check("m8_tag",        m8_out_tag,   4'h4);
        tick();
        m8_valid = 1'b0;
        check("m8_zero_count", m8_count,     0);
        check("m8_zero_tag",   m8_out_tag,   4'h5);
        tick();
        check("m8_mix_count",  m8_count,     2);
        check("m8_mix_tag",    m8_out_tag,   4'h6);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
